// File: rtl/mux3_1.sv
// 3:1 datapath selector with a combinational output plus a registered copy,
// a registered illegal-select flag and a saturating illegal-select counter.
module mux3_1 #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in0,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    input  logic [1:0]           sel,
    output logic [WIDTH-1:0]     out,
    output logic [WIDTH-1:0]     out_q,
    output logic                 sel_err,
    output logic                 sel_err_q,
    output logic [CNT_WIDTH-1:0] err_cnt
);

    logic [WIDTH-1:0]     w_out;
    logic                 w_sel_err;
    logic                 w_cnt_sat;
    logic [WIDTH-1:0]     r_out_q;
    logic                 r_sel_err_q;
    logic [CNT_WIDTH-1:0] r_err_cnt;

    // Unknown select codes fall through to default, so out is zero rather than X.
    always_comb begin
        w_out     = '0;
        w_sel_err = 1'b0;
        case (sel)
            2'b00:   w_out = in0;
            2'b01:   w_out = in1;
            2'b10:   w_out = in2;
            2'b11:   w_sel_err = 1'b1;
            default: begin
            end
        endcase
    end

    assign w_cnt_sat = &r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_q     <= '0;
            r_sel_err_q <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_out_q     <= w_out;
            r_sel_err_q <= w_sel_err;
            // Hold at all-ones instead of wrapping back to zero.
            if (w_sel_err && !w_cnt_sat) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign out       = w_out;
    assign sel_err   = w_sel_err;
    assign out_q     = r_out_q;
    assign sel_err_q = r_sel_err_q;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_mux3_1.sv
// Scoreboard bench for mux3_1: stimulus pushes expected registered state,
// a monitor pops and compares one cycle later; combinational out is checked inline.
module tb_mux3_1;

    localparam int W  = 32;
    localparam int CW = 8;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  in0, in1, in2;
    logic [1:0]    sel;
    logic [W-1:0]  out, out_q;
    logic          sel_err, sel_err_q;
    logic [CW-1:0] err_cnt;

    mux3_1 #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in0(in0), .in1(in1), .in2(in2), .sel(sel),
        .out(out), .out_q(out_q),
        .sel_err(sel_err), .sel_err_q(sel_err_q),
        .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  q;
        logic          e;
        logic [CW-1:0] c;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   err_total = 0;   // illegal-select edges seen since reset (unbounded)

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model_out(input logic [W-1:0] a, b, c, input logic [1:0] s);
        logic [W-1:0] choices [3];
        choices[0] = a; choices[1] = b; choices[2] = c;
        if (s == 2'd3) return '0;
        return choices[s];
    endfunction

    function automatic logic [CW-1:0] model_cnt(input int total);
        int lim;
        lim = (1 << CW) - 1;
        return (total > lim) ? lim[CW-1:0] : total[CW-1:0];
    endfunction

    task automatic apply(input logic [W-1:0] a, b, c, input logic [1:0] s);
        in0 = a; in1 = b; in2 = c; sel = s;
        #1;
        chk("out", out, model_out(a, b, c, s));
        chk("sel_err", sel_err, s == 2'd3);
        $display("txn sel=%0d in0=%h in1=%h in2=%h out=%h sel_err=%0b", s, a, b, c, out, sel_err);
    endtask

    task automatic push_exp();
        exp_t e;
        if (sel == 2'd3) err_total++;
        e.q = model_out(in0, in1, in2, sel);
        e.e = (sel == 2'd3);
        e.c = model_cnt(err_total);
        sb.push_back(e);
    endtask

    task automatic drive(input logic [W-1:0] a, b, c, input logic [1:0] s);
        @(negedge clk);
        apply(a, b, c, s);
        push_exp();
    endtask

    // Monitor: registered outputs are compared just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_q", out_q, e.q);
                chk("sel_err_q", sel_err_q, e.e);
                chk("err_cnt", err_cnt, e.c);
                $display("mon out_q=%h sel_err_q=%0b err_cnt=%0d", out_q, sel_err_q, err_cnt);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        in0 = '0; in1 = '0; in2 = '0; sel = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_q", out_q, 0);
        chk("rst_sel_err_q", sel_err_q, 0);
        chk("rst_err_cnt", err_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic selection and illegal select
        drive(32'hAAAAAAAA, 32'h55555555, 32'hFFFF0000, 2'b00);
        drive(32'hAAAAAAAA, 32'h55555555, 32'hFFFF0000, 2'b01);
        drive(32'hAAAAAAAA, 32'h55555555, 32'hFFFF0000, 2'b10);
        drive(32'hAAAAAAAA, 32'h55555555, 32'hFFFF0000, 2'b11);

        // Sweep select within one low phase, no clocking in between
        @(negedge clk);
        for (int s = 0; s < 3; s++) apply(32'h11111111, 32'h22222222, 32'h33333333, s[1:0]);
        push_exp();

        // Data change with select held and no edge
        drive(32'h11111111, 32'h22222222, 32'h33333333, 2'b01);
        @(posedge clk);
        #3;
        in1 = 32'h44444444;
        #1;
        chk("hold_out", out, 32'h44444444);
        chk("hold_out_q", out_q, 32'h22222222);
        $display("txn in1 changed w/o edge out=%h out_q=%h", out, out_q);

        // Saturation of the illegal-select counter
        for (int i = 0; i < 300; i++) drive($urandom, $urandom, $urandom, 2'b11);
        @(posedge clk);
        #2;
        chk("sat_hold", err_cnt, 8'hFF);

        // Asynchronous reset between edges
        drive(32'hAAAAAAAA, 32'h55555555, 32'hFFFF0000, 2'b00);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_q", out_q, 0);
        chk("arst_sel_err_q", sel_err_q, 0);
        chk("arst_err_cnt", err_cnt, 0);
        chk("arst_out", out, 32'hAAAAAAAA);
        $display("txn async reset out_q=%h err_cnt=%0d out=%h", out_q, err_cnt, out);
        err_total = 0;
        sel = 2'b11;
        @(posedge clk);
        #1;
        chk("rst_hold_err_cnt", err_cnt, 0);
        #3;
        rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            drive($urandom, $urandom, $urandom, 2'($urandom_range(0, 3)));
        end

        repeat (2) @(posedge clk);
        #2;
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
